adc_capture_ctrl: RTL and testbench

Triggered acquisition sequencer for the 14-bit dual-phase ADC capture path. It sits directly downstream of the ADC driver's registered `adc_data_a`/`adc_data_b` outputs and runs in the same sample clock domain. It handles arming, optional decimation, pre-trigger fill, level/slope triggering and post-trigger capture into an external circular sample RAM. When capture completes it hands the window start address to the Ethernet readout logic.

---
 rtl/adc_capture_ctrl_if.sv | 38 +++
 rtl/adc_capture_ctrl.sv | 139 +++++++++++++
 tb/tb_adc_capture_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_capture_ctrl_if.sv
// Signal bundle between the ADC capture sequencer and its surroundings:
// ADC sample inputs, capture control/configuration, sample RAM write port and status.
interface adc_capture_ctrl_if #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 10
);
  logic [DATA_W-1:0]   adc_data_a;
  logic [DATA_W-1:0]   adc_data_b;
  logic                arm;
  logic                abort;
  logic                force_trig;
  logic                trig_slope;
  logic [DATA_W-1:0]   trig_level;
  logic [ADDR_W-1:0]   pre_len;
  logic [ADDR_W:0]     post_len;
  logic [7:0]          dec_div;
  logic                done_ack;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [2*DATA_W-1:0] wr_data;
  logic                busy;
  logic                waiting;
  logic                done;
  logic [ADDR_W-1:0]   trig_addr;
  logic [ADDR_W-1:0]   start_addr;

  modport master (
    output adc_data_a, adc_data_b, arm, abort, force_trig, trig_slope, trig_level,
           pre_len, post_len, dec_div, done_ack,
    input  wr_en, wr_addr, wr_data, busy, waiting, done, trig_addr, start_addr
  );

  modport slave (
    input  adc_data_a, adc_data_b, arm, abort, force_trig, trig_slope, trig_level,
           pre_len, post_len, dec_div, done_ack,
    output wr_en, wr_addr, wr_data, busy, waiting, done, trig_addr, start_addr
  );
endinterface

// File: rtl/adc_capture_ctrl.sv
// Triggered acquisition sequencer: arm, decimate, pre-trigger fill, level/slope or forced
// trigger, post-trigger capture into a circular sample RAM, then hand off the window start.
module adc_capture_ctrl #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 10
) (
  input  logic             clk_sample,
  input  logic             rst_n,
  adc_capture_ctrl_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

  localparam logic [ADDR_W:0]   DEPTH_W = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              r_state, w_next;
  logic                r_slope, r_prev_valid, r_force_pend;
  logic [DATA_W-1:0]   r_level, r_prev;
  logic [ADDR_W-1:0]   r_pre_eff, r_ptr;
  logic [ADDR_W:0]     r_post_eff, r_cnt;
  logic [7:0]          r_dec_div, r_dec_cnt;
  logic                r_wr_en, r_busy, r_waiting, r_done;
  logic [ADDR_W-1:0]   r_wr_addr, r_trig_addr, r_start_addr;
  logic [2*DATA_W-1:0] r_wr_data;

  logic                w_active, w_strobe, w_edge, w_trig, w_arm;
  logic [ADDR_W:0]     w_cnt_inc, w_post_min1, w_room, w_post_eff;

  // pre_len is ADDR_W bits wide, so it can never exceed DEPTH-1 and needs no clamp.
  assign w_post_min1 = (bus.post_len == '0) ? CNT_ONE : bus.post_len;
  assign w_room      = DEPTH_W - {1'b0, bus.pre_len};
  assign w_post_eff  = (w_post_min1 > w_room) ? w_room : w_post_min1;

  assign w_active  = (r_state == S_PRE) || (r_state == S_WAIT) || (r_state == S_POST);
  assign w_strobe  = w_active && (r_dec_cnt == 8'd0) && !bus.abort;
  assign w_cnt_inc = r_cnt + CNT_ONE;
  assign w_arm     = (r_state == S_IDLE) && bus.arm && !bus.abort;

  assign w_edge = r_prev_valid &&
                  (r_slope ? ((r_prev > r_level) && (bus.adc_data_a <= r_level))
                           : ((r_prev < r_level) && (bus.adc_data_a >= r_level)));
  assign w_trig = (r_state == S_WAIT) && w_strobe && (r_force_pend || w_edge);

  // NOTE: w_next gets its default before the case so no latch is inferred.
  always_comb begin
    w_next = r_state;
    if (bus.abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (bus.arm) w_next = (bus.pre_len == '0) ? S_WAIT : S_PRE;
        S_PRE:  if (w_strobe && (w_cnt_inc == {1'b0, r_pre_eff})) w_next = S_WAIT;
        S_WAIT: if (w_trig) w_next = (r_post_eff == CNT_ONE) ? S_DONE : S_POST;
        S_POST: if (w_strobe && (w_cnt_inc == r_post_eff)) w_next = S_DONE;
        S_DONE: if (bus.done_ack) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; later assignments in the
  // block intentionally override earlier ones (trigger over strobe count, abort over force).
  always_ff @(posedge clk_sample or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_slope      <= 1'b0;
      r_level      <= '0;
      r_pre_eff    <= '0;
      r_post_eff   <= CNT_ONE;
      r_dec_div    <= 8'd0;
      r_dec_cnt    <= 8'd0;
      r_ptr        <= '0;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_force_pend <= 1'b0;
      r_cnt        <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_trig_addr  <= '0;
      r_start_addr <= '0;
      r_busy       <= 1'b0;
      r_waiting    <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_busy    <= (w_next != S_IDLE);
      r_waiting <= (w_next == S_WAIT);
      r_done    <= (w_next == S_DONE);
      r_wr_en   <= w_strobe;

      if (w_active) r_dec_cnt <= (r_dec_cnt == r_dec_div) ? 8'd0 : r_dec_cnt + 8'd1;

      if (w_strobe) begin
        r_wr_addr    <= r_ptr;
        r_wr_data    <= {bus.adc_data_b, bus.adc_data_a};
        r_ptr        <= r_ptr + PTR_ONE;
        r_prev       <= bus.adc_data_a;
        r_prev_valid <= 1'b1;
        r_cnt        <= w_cnt_inc;
      end

      if ((r_state == S_WAIT) && bus.force_trig) r_force_pend <= 1'b1;

      if (w_trig) begin
        r_trig_addr  <= r_ptr;
        r_start_addr <= r_ptr - r_pre_eff;
        r_cnt        <= CNT_ONE;
        r_force_pend <= 1'b0;
      end

      if (w_arm) begin
        r_slope      <= bus.trig_slope;
        r_level      <= bus.trig_level;
        r_pre_eff    <= bus.pre_len;
        r_post_eff   <= w_post_eff;
        r_dec_div    <= bus.dec_div;
        r_dec_cnt    <= 8'd0;
        r_ptr        <= '0;
        r_wr_addr    <= '0;
        r_prev_valid <= 1'b0;
        r_force_pend <= 1'b0;
        r_cnt        <= '0;
      end

      if (bus.abort) r_force_pend <= 1'b0;
    end
  end

  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.busy       = r_busy;
  assign bus.waiting    = r_waiting;
  assign bus.done       = r_done;
  assign bus.trig_addr  = r_trig_addr;
  assign bus.start_addr = r_start_addr;
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl: a 1024-deep and a 16-deep instance run in lockstep
// from the same stimulus; each scenario checks whichever instance exercises its boundary.
module tb_adc_capture_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] a, b, level;
  logic        arm, abort, force_trig, slope, done_ack;
  logic [9:0]  pre_len;
  logic [10:0] post_len;
  logic [7:0]  dec_div;

  int n_checks = 0;
  int n_errors = 0;

  adc_capture_ctrl_if #(.DATA_W(14), .ADDR_W(10)) bus10 ();
  adc_capture_ctrl_if #(.DATA_W(14), .ADDR_W(4))  bus4 ();

  assign bus10.adc_data_a = a;          assign bus4.adc_data_a = a;
  assign bus10.adc_data_b = b;          assign bus4.adc_data_b = b;
  assign bus10.arm        = arm;        assign bus4.arm        = arm;
  assign bus10.abort      = abort;      assign bus4.abort      = abort;
  assign bus10.force_trig = force_trig; assign bus4.force_trig = force_trig;
  assign bus10.trig_slope = slope;      assign bus4.trig_slope = slope;
  assign bus10.trig_level = level;      assign bus4.trig_level = level;
  assign bus10.pre_len    = pre_len;    assign bus4.pre_len    = pre_len[3:0];
  assign bus10.post_len   = post_len;   assign bus4.post_len   = post_len[4:0];
  assign bus10.dec_div    = dec_div;    assign bus4.dec_div    = dec_div;
  assign bus10.done_ack   = done_ack;   assign bus4.done_ack   = done_ack;

  adc_capture_ctrl #(.DATA_W(14), .ADDR_W(10)) dut (
    .clk_sample(clk), .rst_n(rst_n), .bus(bus10.slave));
  adc_capture_ctrl #(.DATA_W(14), .ADDR_W(4)) dut_s (
    .clk_sample(clk), .rst_n(rst_n), .bus(bus4.slave));

  always #5 clk = ~clk;

  // Write scoreboard for the large instance, plus write counts and spacing.
  logic [27:0] mem10 [1024];
  bit          written [1024];
  int wr_cnt10, wr_cnt4, cyc, last_wr, bad_gap;
  bit have_last, gap_check;

  always @(negedge clk) begin
    cyc++;
    if (bus10.wr_en) begin
      wr_cnt10++;
      written[bus10.wr_addr] = 1'b1;
      mem10[bus10.wr_addr]   = bus10.wr_data;
      if (gap_check && have_last && (cyc - last_wr != 4)) bad_gap++;
      last_wr   = cyc;
      have_last = 1'b1;
    end
    if (bus4.wr_en) wr_cnt4++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_sb();
    for (int i = 0; i < 1024; i++) begin
      written[i] = 1'b0;
      mem10[i]   = 'x;
    end
    wr_cnt10 = 0; wr_cnt4 = 0; bad_gap = 0; have_last = 1'b0;
  endtask

  task automatic arm_capture();
    step();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic idle_all();
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
  endtask

  int done_c;

  initial begin
    rst_n = 1'b0; a = '0; b = '0; level = '0; arm = 1'b0; abort = 1'b0;
    force_trig = 1'b0; slope = 1'b0; done_ack = 1'b0; pre_len = '0; post_len = '0;
    dec_div = '0; gap_check = 1'b0;
    clear_sb();
    repeat (3) step();
    check("rst_busy", 32'(bus10.busy), 0);
    check("rst_wr_en", 32'(bus10.wr_en), 0);
    check("rst_done", 32'(bus10.done), 0);
    rst_n = 1'b1;
    step();

    // Rising ramp 990,992,...; PRE fills addr 0..3, 998 at addr 4, 1000 triggers at addr 5.
    dec_div = 8'd0; pre_len = 10'd4; post_len = 11'd4; level = 14'd1000; slope = 1'b0;
    clear_sb();
    arm_capture();
    check("t1_busy_after_arm", 32'(bus10.busy), 1);
    check("t1_wr_en_n1", 32'(bus10.wr_en), 0);
    done_c = -1;
    for (int k = 0; k < 40 && done_c < 0; k++) begin
      a = 14'(990 + 2 * k);
      b = 14'(k);
      step();
      if (k == 0) check("t1_first_wr", 32'(bus10.wr_en), 1);
      if (bus10.done) done_c = k;
    end
    check("t1_done_k", 32'(done_c), 8);
    check("t1_pre_last", 32'(mem10[3]), {14'd3, 14'd996});
    check("t1_trig_sample", 32'(mem10[5]), {14'd5, 14'd1000});
    check("t1_trig_addr", 32'(bus10.trig_addr), 5);
    check("t1_start_addr", 32'(bus10.start_addr), 1);
    check("t1_last_post", 32'(written[8]), 1);
    check("t1_no_extra", 32'(written[9]), 0);
    repeat (5) step();
    check("t1_done_held", 32'(bus10.done), 1);
    check("t1_writes", 32'(wr_cnt10), 9);
    done_ack = 1'b1;
    step();
    done_ack = 1'b0;
    check("t1_ack_done", 32'(bus10.done), 0);
    check("t1_ack_busy", 32'(bus10.busy), 0);
    idle_all();

    // 16-deep wrap: 23 zero samples then 4000; trigger on write 23 -> addr 7, start 4.
    pre_len = 10'd3; post_len = 11'd4; level = 14'd2000; b = '0;
    clear_sb();
    arm_capture();
    done_c = -1;
    for (int k = 0; k < 40 && done_c < 0; k++) begin
      a = (k < 23) ? 14'd0 : 14'd4000;
      step();
      if (k == 22) check("t2_wait_before", 32'(bus4.waiting), 1);
      if (k == 23) begin
        check("t2_wait_fall", 32'(bus4.waiting), 0);
        check("t2_trig_addr", 32'(bus4.trig_addr), 7);
      end
      if (bus4.done) done_c = k;
    end
    check("t2_done_k", 32'(done_c), 26);
    check("t2_start_addr", 32'(bus4.start_addr), 4);
    check("t2_writes", 32'(wr_cnt4), 27);
    idle_all();

    // Decimation by 4, falling at 500: the 400 dip at c=9..11 lies between strobes.
    dec_div = 8'd3; pre_len = 10'd2; post_len = 11'd2; slope = 1'b1; level = 14'd500;
    clear_sb();
    gap_check = 1'b1;
    arm_capture();
    done_c = -1;
    for (int c = 0; c < 40 && done_c < 0; c++) begin
      a = (c >= 9 && c <= 11) ? 14'd400 : (c >= 16) ? 14'd450 : 14'd800;
      step();
      if (bus10.done) done_c = c;
    end
    gap_check = 1'b0;
    check("t3_done_c", 32'(done_c), 20);
    check("t3_trig_addr", 32'(bus10.trig_addr), 4);
    check("t3_start_addr", 32'(bus10.start_addr), 2);
    check("t3_trig_sample", 32'(mem10[4][13:0]), 450);
    check("t3_writes", 32'(wr_cnt10), 6);
    check("t3_gap", 32'(bad_gap), 0);
    idle_all();

    // Force: pulse in PRE (c=1) ignored; pulse at c=21 triggers strobe c=24 (addr 6).
    dec_div = 8'd3; pre_len = 10'd2; post_len = 11'd1; slope = 1'b0; level = 14'd1000;
    a = 14'd100;
    clear_sb();
    arm_capture();
    done_c = -1;
    for (int c = 0; c < 40 && done_c < 0; c++) begin
      force_trig = (c == 1) || (c == 21);
      step();
      force_trig = 1'b0;
      if (c == 19) check("t4_pre_force_ignored", 32'(bus10.waiting), 1);
      if (c == 23) check("t4_pending_wait", 32'(bus10.waiting), 1);
      if (bus10.done) done_c = c;
    end
    check("t4_done_c", 32'(done_c), 24);
    check("t4_trig_addr", 32'(bus10.trig_addr), 6);
    check("t4_start_addr", 32'(bus10.start_addr), 4);
    check("t4_writes", 32'(wr_cnt10), 7);
    idle_all();

    // Abort mid-POST with an ignored arm before it; then arm+abort together in IDLE.
    dec_div = 8'd0; pre_len = 10'd2; post_len = 11'd8; a = 14'd100;
    clear_sb();
    arm_capture();
    for (int c = 0; c < 7; c++) begin
      force_trig = (c == 2);
      arm        = (c == 4);
      abort      = (c == 6);
      step();
      force_trig = 1'b0; arm = 1'b0; abort = 1'b0;
      if (c == 3) check("t5_trig_addr", 32'(bus10.trig_addr), 3);
      if (c == 5) begin
        check("t5_arm_ignored_addr", 32'(bus10.wr_addr), 5);
        check("t5_arm_ignored_busy", 32'(bus10.busy), 1);
      end
      if (c == 6) begin
        check("t5_abort_busy", 32'(bus10.busy), 0);
        check("t5_abort_wr_en", 32'(bus10.wr_en), 0);
      end
    end
    repeat (4) step();
    check("t5_abort_writes", 32'(wr_cnt10), 6);
    check("t5_abort_done", 32'(bus10.done), 0);
    arm = 1'b1; abort = 1'b1;
    step();
    arm = 1'b0; abort = 1'b0;
    check("t5_armabort_busy", 32'(bus10.busy), 0);
    repeat (3) step();
    check("t5_armabort_nowr", 32'(wr_cnt10), 6);

    // Zero lengths: stale prev=100 must not make 1200 on the first strobe trigger.
    pre_len = 10'd0; post_len = 11'd0; level = 14'd1000; slope = 1'b0;
    clear_sb();
    arm_capture();
    check("t6_wait_direct", 32'(bus10.waiting), 1);
    done_c = -1;
    for (int c = 0; c < 10 && done_c < 0; c++) begin
      a = (c == 0) ? 14'd1200 : (c == 1) ? 14'd900 : 14'd1100;
      step();
      if (bus10.done) done_c = c;
    end
    check("t6_done_c", 32'(done_c), 2);
    check("t6_trig_addr", 32'(bus10.trig_addr), 2);
    check("t6_start_addr", 32'(bus10.start_addr), 2);
    check("t6_writes", 32'(wr_cnt10), 3);
    idle_all();

    // 16-deep clamp: pre 12, post 10 -> post_eff 4; forced trigger at addr 13.
    pre_len = 10'd12; post_len = 11'd10; a = 14'd100;
    clear_sb();
    arm_capture();
    done_c = -1;
    for (int c = 0; c < 30 && done_c < 0; c++) begin
      force_trig = (c == 12);
      step();
      force_trig = 1'b0;
      if (bus4.done) done_c = c;
    end
    check("t7_done_c", 32'(done_c), 16);
    check("t7_trig_addr", 32'(bus4.trig_addr), 13);
    check("t7_start_addr", 32'(bus4.start_addr), 1);
    check("t7_writes", 32'(wr_cnt4), 17);
    check("t7_large_not_done", 32'(bus10.done), 0);
    idle_all();

    // Reset asserted mid-WAIT_TRIG clears every output without waiting for a clock.
    pre_len = 10'd0; post_len = 11'd4; level = 14'd1000; a = 14'd100; b = 14'd7;
    arm_capture();
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check("t8_wr_en", 32'(bus10.wr_en), 0);
    check("t8_busy", 32'(bus10.busy), 0);
    check("t8_waiting", 32'(bus10.waiting), 0);
    check("t8_done", 32'(bus10.done), 0);
    check("t8_wr_addr", 32'(bus10.wr_addr), 0);
    check("t8_wr_data", 32'(bus10.wr_data), 0);
    check("t8_trig_addr", 32'(bus10.trig_addr), 0);
    check("t8_start_addr", 32'(bus10.start_addr), 0);
    step();
    rst_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
